// File: rtl/closure_pkg.sv
// Shared defaults, FSM encoding and peak-to-peak saturation limit for the
// closure-phase decimator.
package closure_pkg;

  localparam int LOG2_DEC_DEF   = 12;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Largest positive value of a signed word; peak-to-peak is clamped to it.
  localparam logic [DATA_WIDTH_DEF-1:0] PP_SAT_DEF = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};

  // Same limit for an arbitrary word width (up to 64 bits).
  function automatic logic [63:0] pp_sat_value(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/closure_phase_decimator_running_extrema.sv
// Running minimum/maximum of a signed sample stream. A seed loads both
// extrema from the sample; an update widens them to include the sample.
module running_extrema
  import closure_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         seed,
  input  logic                         update,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [DATA_WIDTH-1:0] min,
  output logic signed [DATA_WIDTH-1:0] max
);

  // Seed takes priority; otherwise track the extremes of accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min <= '0;
      max <= '0;
    end else if (seed) begin
      min <= sample;
      max <= sample;
    end else if (update) begin
      if (sample < min) min <= sample;
      if (sample > max) max <= sample;
    end
  end

endmodule

// File: rtl/closure_phase_decimator.sv
// Decimates a closure-phase stream into blocks of 2^LOG2_DEC samples and
// emits the block mean and peak-to-peak on a shared-valid stream output.
module closure_phase_decimator
  import closure_pkg::*;
#(
  parameter int LOG2_DEC   = LOG2_DEC_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] phase_in,
  input  logic                         phase_valid,
  input  logic                         clr_ovr,
  output logic signed [DATA_WIDTH-1:0] M_AXIS_MEAN_tdata,
  output logic        [DATA_WIDTH-1:0] M_AXIS_PP_tdata,
  output logic                         M_AXIS_tvalid,
  input  logic                         M_AXIS_tready,
  output logic                         overrun
);

  localparam int ACC_W = DATA_WIDTH + LOG2_DEC;
  localparam logic [DATA_WIDTH-1:0] PP_SAT = DATA_WIDTH'(pp_sat_value(DATA_WIDTH));

  state_e state_q, state_d;

  logic        [LOG2_DEC-1:0]   cnt_p0;
  logic signed [ACC_W-1:0]      acc_p0;
  logic signed [DATA_WIDTH-1:0] min_p0, max_p0;

  logic signed [DATA_WIDTH-1:0] mean_p1;
  logic        [DATA_WIDTH-1:0] pp_p1;
  logic                         vld_p1;
  logic                         ovr_q;

  logic                         accept, last, blk_clr;
  logic                         ext_seed, ext_update;
  logic signed [DATA_WIDTH-1:0] ext_sample;
  logic signed [ACC_W-1:0]      sample_ext, sum;
  logic signed [DATA_WIDTH-1:0] fmin, fmax;
  logic        [DATA_WIDTH:0]   diff;

  // Floor mean: arithmetic shift of the full block sum.
  function automatic logic signed [DATA_WIDTH-1:0] round_mean(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] sh;
    sh = s >>> LOG2_DEC;
    return sh[DATA_WIDTH-1:0];
  endfunction

  // Clamp the (non-negative) extrema spread to the largest signed word.
  function automatic logic [DATA_WIDTH-1:0] sat_pp(input logic [DATA_WIDTH:0] d);
    if (d > {1'b0, PP_SAT}) return PP_SAT;
    return d[DATA_WIDTH-1:0];
  endfunction

  assign accept     = (state_q == ST_RUN) && en && phase_valid;
  assign last       = accept && (cnt_p0 == {LOG2_DEC{1'b1}});
  assign blk_clr    = !en;
  assign sample_ext = {{LOG2_DEC{phase_in[DATA_WIDTH-1]}}, phase_in};
  assign sum        = acc_p0 + sample_ext;
  assign fmax       = (phase_in > max_p0) ? phase_in : max_p0;
  assign fmin       = (phase_in < min_p0) ? phase_in : min_p0;
  assign diff       = {fmax[DATA_WIDTH-1], fmax} - {fmin[DATA_WIDTH-1], fmin};

  // Dropping en zeroes the extrema by seeding them with 0.
  assign ext_seed   = blk_clr || (accept && (cnt_p0 == '0));
  assign ext_update = accept;
  assign ext_sample = blk_clr ? '0 : phase_in;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: run follows en.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)  state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- stage p0: block accumulation ----
  // Count and sum accepted samples; the last sample wraps and reseeds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (blk_clr) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
    end else if (accept) begin
      cnt_p0 <= cnt_p0 + 1'b1;
      acc_p0 <= last ? '0 : sum;
    end
  end

  running_extrema #(.DATA_WIDTH(DATA_WIDTH)) u_extrema (
    .clk    (clk),
    .rst    (rst),
    .seed   (ext_seed),
    .update (ext_update),
    .sample (ext_sample),
    .min    (min_p0),
    .max    (max_p0)
  );

  // ---- stage p1: result hold and handshake ----
  // Load a finished block unless a held result is still unaccepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mean_p1 <= '0;
      pp_p1   <= '0;
      vld_p1  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (last && (!vld_p1 || M_AXIS_tready)) begin
        mean_p1 <= round_mean(sum);
        pp_p1   <= sat_pp(diff);
        vld_p1  <= 1'b1;
      end else if (vld_p1 && M_AXIS_tready) begin
        vld_p1  <= 1'b0;
      end
      if (last && vld_p1 && !M_AXIS_tready) ovr_q <= 1'b1;
      else if (clr_ovr)                     ovr_q <= 1'b0;
    end
  end

  assign M_AXIS_MEAN_tdata = mean_p1;
  assign M_AXIS_PP_tdata   = pp_p1;
  assign M_AXIS_tvalid     = vld_p1;
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_closure_phase_decimator.sv
// Bench for closure_phase_decimator with N=4: directed cases plus a random
// run, all compared against a block-level reference model.
module tb_closure_phase_decimator;

  localparam int LD = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          phase_valid = 1'b0;
  logic          clr_ovr = 1'b0;
  logic          tready = 1'b0;
  logic [DW-1:0] phase_in = '0;
  logic [DW-1:0] mean_w, pp_w;
  logic          tvalid, overrun;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_run = 1'b0;
  bit          m_vld = 1'b0;
  bit          m_ovr = 1'b0;
  logic [31:0] m_mean = '0;
  logic [31:0] m_pp = '0;
  longint      blk[$];

  closure_phase_decimator #(.LOG2_DEC(LD), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .en                (en),
    .phase_in          (phase_in),
    .phase_valid       (phase_valid),
    .clr_ovr           (clr_ovr),
    .M_AXIS_MEAN_tdata (mean_w),
    .M_AXIS_PP_tdata   (pp_w),
    .M_AXIS_tvalid     (tvalid),
    .M_AXIS_tready     (tready),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_vld = 1'b0; m_ovr = 1'b0;
    m_mean = '0; m_pp = '0;
    blk.delete();
  endtask

  // One clock of the specified behaviour, computed from whole blocks.
  task automatic model_step(input bit e, input bit v, input logic [31:0] s,
                            input bit r, input bit c);
    bit due = 1'b0;
    bit drop = 1'b0;
    longint sum, mn, mx, q, d;
    sum = 0; mn = 0; mx = 0; q = 0; d = 0;
    if (!e) blk.delete();
    else if (m_run && v) begin
      blk.push_back(longint'($signed(s)));
      if (blk.size() == 4) begin
        mn = blk[0]; mx = blk[0];
        foreach (blk[i]) begin
          sum += blk[i];
          if (blk[i] < mn) mn = blk[i];
          if (blk[i] > mx) mx = blk[i];
        end
        q = sum / 4;
        if (sum < 0 && q * 4 != sum) q = q - 1;
        d = mx - mn;
        if (d > 64'sd2147483647) d = 64'sd2147483647;
        due = 1'b1;
        blk.delete();
      end
    end
    if (due) begin
      if (!m_vld || r) begin
        m_mean = q[31:0]; m_pp = d[31:0]; m_vld = 1'b1;
      end else drop = 1'b1;
    end else if (m_vld && r) m_vld = 1'b0;
    if (drop) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
    m_run = e;
  endtask

  task automatic cycle(input bit e, input bit v, input logic [31:0] s,
                       input bit r, input bit c);
    en = e; phase_valid = v; phase_in = s; tready = r; clr_ovr = c;
    model_step(e, v, s, r, c);
    @(posedge clk);
    #1;
    check_eq("tvalid", {31'd0, tvalid}, {31'd0, m_vld});
    check_eq("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (m_vld) begin
      check_eq("mean", mean_w, m_mean);
      check_eq("pp", pp_w, m_pp);
    end
  endtask

  function automatic logic [31:0] rand_sample();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return $urandom();
      default: return 32'($signed($urandom_range(0, 100)) - 50);
    endcase
  endfunction

  initial begin
    // reset state
    #3;
    check_eq("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check_eq("rst_mean", mean_w, 32'd0);
    check_eq("rst_pp", pp_w, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // basic averaging
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 32'd10, 1, 0);
    cycle(1, 1, 32'd20, 1, 0);
    cycle(1, 1, 32'd30, 1, 0);
    cycle(1, 1, 32'd41, 1, 0);
    check_eq("avg_tvalid", {31'd0, tvalid}, 32'd1);
    check_eq("avg_mean", mean_w, 32'd25);
    check_eq("avg_pp", pp_w, 32'd31);
    cycle(1, 0, 0, 1, 0);
    check_eq("avg_tvalid_drop", {31'd0, tvalid}, 32'd0);

    // negatives and floor rounding
    cycle(1, 1, 32'hFFFFFFFF, 1, 0);
    cycle(1, 1, 32'hFFFFFFFE, 1, 0);
    cycle(1, 1, 32'hFFFFFFFE, 1, 0);
    cycle(1, 1, 32'hFFFFFFFE, 1, 0);
    check_eq("neg_mean", mean_w, 32'hFFFFFFFE);
    check_eq("neg_pp", pp_w, 32'd1);

    // saturation
    cycle(1, 1, 32'h7FFFFFFF, 1, 0);
    cycle(1, 1, 32'h80000000, 1, 0);
    cycle(1, 1, 32'd0, 1, 0);
    cycle(1, 1, 32'd0, 1, 0);
    check_eq("sat_pp", pp_w, 32'h7FFFFFFF);
    check_eq("sat_mean", mean_w, 32'hFFFFFFFF);
    cycle(1, 0, 0, 1, 0);

    // overrun: 8 samples with the sink stalled
    for (int i = 1; i <= 8; i++) cycle(1, 1, 32'(i), 0, 0);
    check_eq("ovr_flag", {31'd0, overrun}, 32'd1);
    check_eq("ovr_mean_held", mean_w, 32'd2);
    check_eq("ovr_pp_held", pp_w, 32'd3);
    cycle(1, 0, 0, 0, 1);
    check_eq("ovr_cleared", {31'd0, overrun}, 32'd0);
    check_eq("ovr_still_valid", {31'd0, tvalid}, 32'd1);
    cycle(1, 0, 0, 1, 0);

    // accept and new result on the same edge
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'd8, 0, 0);
    check_eq("simul_first", mean_w, 32'd8);
    for (int i = 0; i < 3; i++) cycle(1, 1, 32'hFFFFFFF0, 0, 0);
    cycle(1, 1, 32'hFFFFFFF0, 1, 0);
    check_eq("simul_mean", mean_w, 32'hFFFFFFF0);
    check_eq("simul_tvalid", {31'd0, tvalid}, 32'd1);
    check_eq("simul_overrun", {31'd0, overrun}, 32'd0);
    cycle(1, 0, 0, 1, 0);

    // en dropped mid-block; the sample during the IDLE cycle is ignored
    cycle(1, 1, 32'd5, 1, 0);
    cycle(1, 1, 32'd7, 1, 0);
    cycle(0, 1, 32'd9, 1, 0);
    cycle(1, 1, 32'd999, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'd100, 1, 0);
    check_eq("abort_mean", mean_w, 32'd100);
    check_eq("abort_pp", pp_w, 32'd0);
    cycle(1, 0, 0, 1, 0);

    // asynchronous reset with a held result and a partial block
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'd3, 0, 0);
    cycle(1, 1, 32'd9, 0, 0);
    cycle(1, 1, 32'd9, 0, 0);
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_tvalid", {31'd0, tvalid}, 32'd0);
    check_eq("midrst_mean", mean_w, 32'd0);
    check_eq("midrst_pp", pp_w, 32'd0);
    check_eq("midrst_overrun", {31'd0, overrun}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 32'd50, 1, 0);
    check_eq("postrst_mean", mean_w, 32'd50);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), rand_sample(),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/closure_phase_decimator.md
CLOSURE_PHASE_DECIMATOR -- requirements
Module: closure_phase_decimator

Interface
REQ-001 SHALL have parameter LOG2_DEC, default 12, meaning block length N = 2^LOG2_DEC samples (legal range 1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the closure-phase input and of both result words.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  run enable; low discards any partial block.
REQ-006 SHALL have port phase_in  input  DATA_WIDTH  signed closure phase (PE_A - PE_B + PE_C), one sample per clk.
REQ-007 SHALL have port phase_valid  input  1  phase_in qualifier.
REQ-008 SHALL have port clr_ovr  input  1  clears the sticky overrun flag.
REQ-009 SHALL have port M_AXIS_MEAN_tdata  output  DATA_WIDTH  signed block mean.
REQ-010 SHALL have port M_AXIS_PP_tdata  output  DATA_WIDTH  unsigned block peak-to-peak.
REQ-011 SHALL have port M_AXIS_tvalid  output  1  result valid, shared by both tdata ports.
REQ-012 SHALL have port M_AXIS_tready  input  1  downstream accept.
REQ-013 SHALL have port overrun  output  1  sticky flag: a result was dropped.

Function
REQ-014 SHALL run a two-state FSM: IDLE -> RUN when en=1; RUN -> IDLE when en=0; reset enters IDLE.
REQ-015 SHALL accept a sample only in RUN with phase_valid=1; samples arriving in IDLE are ignored.
REQ-016 SHALL accumulate accepted samples, sign-extended, into a (DATA_WIDTH+LOG2_DEC)-bit accumulator that never overflows.
REQ-017 SHALL track the running minimum and maximum of the block, both seeded by the block's first sample.
REQ-018 SHALL count accepted samples 0..N-1; on the edge that accepts sample N-1, the count SHALL wrap to 0 and the accumulator and extrema SHALL reseed, with no gap cycle.
REQ-019 SHALL, on that same edge, load MEAN = (acc + sample) arithmetic-shifted right by LOG2_DEC (floor).
REQ-020 SHALL, on that same edge, load PP = final max - final min, computed in DATA_WIDTH+1 bits and saturated to 2^(DATA_WIDTH-1)-1.
REQ-021 SHALL raise tvalid on the cycle after the last sample edge (latency 1 clk).
REQ-022 SHALL hold tvalid and both tdata values stable until a tvalid=1 and tready=1 edge.
REQ-023 SHALL, if a new result is due while tvalid=1 and tready=0, drop the new result, keep the held one, and set overrun.
REQ-024 SHALL, if a new result is due on a tvalid=1 and tready=1 edge, load the new result and keep tvalid=1.
REQ-025 SHALL clear overrun when clr_ovr=1; if clr_ovr and a new drop occur on the same edge, set SHALL win.
REQ-026 SHALL, when en falls mid-block, zero the count, accumulator and extrema; a held output result SHALL remain valid until it is accepted.

Reset
REQ-027 SHALL, while rst=0, force state=IDLE, count=0, acc=0, min=max=0, MEAN=0, PP=0, tvalid=0 and overrun=0, asynchronously.
REQ-028 SHALL, on a reset mid-block or mid-handshake, discard the partial block and any held result; the first result after release SHALL need a full N samples.

Structure
REQ-029 SHALL place the LOG2_DEC and DATA_WIDTH defaults, the FSM state enumeration and the PP saturation constant in shared package closure_pkg.
REQ-030 SHALL implement the min/max tracker as a single sub-module, running_extrema, with inputs seed/update/sample and outputs min/max.

Verification (bench uses LOG2_DEC=2, N=4)
REQ-031 SHALL check basic averaging: en=1, tready=1, samples 10, 20, 30, 41 -> one cycle after the 4th sample, MEAN=25 and PP=31, with tvalid high for 1 clk.
REQ-032 SHALL check negatives and floor rounding: samples -1, -2, -2, -2 -> MEAN=-2 and PP=1.
REQ-033 SHALL check saturation: samples 0x7FFFFFFF, 0x80000000, 0, 0 -> PP=0x7FFFFFFF and MEAN=-1.
REQ-034 SHALL check overrun: tready=0 for 8 valid samples -> first result held unchanged, overrun=1 after the 8th sample; then clr_ovr pulse -> overrun=0.
REQ-035 SHALL check the simultaneous case: tready=1 on the same edge the second result completes -> second result loaded and tvalid stays 1.
REQ-036 SHALL check abort paths: en dropped after 2 samples, then 4 samples of 100 -> MEAN=100; rst asserted mid-block -> all outputs 0 immediately.
